// File: rtl/sudoku_checker_pkg.sv
// Shared types and constants for the 4x4 sudoku checker.
// Board words are NUM_ROWS digits of DIGIT_W bits, leftmost column in the top nibble.
package sudoku_checker_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        READ = 3'd2,
        LAST = 3'd3,
        EVAL = 3'd4,
        DONE = 3'd5
    } checkState_t;

    localparam int NUM_ROWS   = 4;
    localparam int DIGIT_W    = 4;
    localparam int ROW_W      = NUM_ROWS * DIGIT_W;
    localparam int ADDR_W     = 2;
    localparam int RAM_W      = 20;

    // Field positions inside one board-RAM word
    localparam int WP_MSB     = 19;
    localparam int WP_LSB     = 16;
    localparam int DIGITS_MSB = 15;
    localparam int DIGITS_LSB = 0;

    // Column 0 is the most significant digit of a row
    function automatic logic [DIGIT_W-1:0] rowDigit(input logic [ROW_W-1:0] row, input int col);
        return row[ROW_W-1-col*DIGIT_W -: DIGIT_W];
    endfunction

endpackage

// File: rtl/sudoku_group_check.sv
// Combinational test that four digits are exactly a permutation of 1..4.
module sudoku_group_check
    import sudoku_checker_pkg::*;
(
    input  logic [DIGIT_W-1:0] d0,
    input  logic [DIGIT_W-1:0] d1,
    input  logic [DIGIT_W-1:0] d2,
    input  logic [DIGIT_W-1:0] d3,
    output logic               isPerm
);

    logic [DIGIT_W-1:0] group [4];
    logic [3:0]         seen;

    assign group[0] = d0;
    assign group[1] = d1;
    assign group[2] = d2;
    assign group[3] = d3;

    // Four cells covering all four values forces them distinct and in range
    always_comb begin
        seen = '0;
        for (int i = 0; i < 4; i++) begin
            case (group[i])
                4'd1:    seen[0] = 1'b1;
                4'd2:    seen[1] = 1'b1;
                4'd3:    seen[2] = 1'b1;
                4'd4:    seen[3] = 1'b1;
                default: ;
            endcase
        end
        isPerm = (seen == 4'hF);
    end

endmodule

// File: rtl/sudoku_checker.sv
// Reads a 4x4 board from shared RAM row by row and reports solved/filled.
// Define CHECKER_BOXES_EN to also require each 2x2 box to hold 1..4.
module sudoku_checker
    import sudoku_checker_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic              busGrant,
    output logic              busReq,
    output logic [ADDR_W-1:0] RamAddr,
    input  logic [RAM_W-1:0]  RamDat,
    output logic              busy,
    output logic              done,
    output logic              solved,
    output logic              filled
);

    checkState_t         state;
    logic [ROW_W-1:0]    rows [NUM_ROWS];
    logic [NUM_ROWS-1:0] rowOk;
    logic [NUM_ROWS-1:0] colOk;
    logic                boxesOk;
    logic                boardSolved;
    logic                boardFilled;
    logic                unusedWpBits;

    assign unusedWpBits = ^RamDat[WP_MSB:WP_LSB];

    for (genvar r = 0; r < NUM_ROWS; r++) begin : gRow
        sudoku_group_check uRowCheck (
            .d0     (rowDigit(rows[r], 0)),
            .d1     (rowDigit(rows[r], 1)),
            .d2     (rowDigit(rows[r], 2)),
            .d3     (rowDigit(rows[r], 3)),
            .isPerm (rowOk[r])
        );
    end

    for (genvar c = 0; c < NUM_ROWS; c++) begin : gCol
        sudoku_group_check uColCheck (
            .d0     (rowDigit(rows[0], c)),
            .d1     (rowDigit(rows[1], c)),
            .d2     (rowDigit(rows[2], c)),
            .d3     (rowDigit(rows[3], c)),
            .isPerm (colOk[c])
        );
    end

`ifdef CHECKER_BOXES_EN
    logic [3:0] boxOk;

    // Box b covers rows 2*(b/2)..+1 and columns 2*(b%2)..+1
    for (genvar b = 0; b < 4; b++) begin : gBox
        localparam int R0 = 2 * (b / 2);
        localparam int C0 = 2 * (b % 2);
        sudoku_group_check uBoxCheck (
            .d0     (rowDigit(rows[R0],     C0)),
            .d1     (rowDigit(rows[R0],     C0 + 1)),
            .d2     (rowDigit(rows[R0 + 1], C0)),
            .d3     (rowDigit(rows[R0 + 1], C0 + 1)),
            .isPerm (boxOk[b])
        );
    end

    assign boxesOk = &boxOk;
`else
    assign boxesOk = 1'b1;
`endif

    assign boardSolved = (&rowOk) & (&colOk) & boxesOk;

    always_comb begin
        boardFilled = 1'b1;
        for (int r = 0; r < NUM_ROWS; r++) begin
            for (int c = 0; c < NUM_ROWS; c++) begin
                if (rowDigit(rows[r], c) == '0) begin
                    boardFilled = 1'b0;
                end
            end
        end
    end

    // RAM data lags the address by one cycle, so READ stores the row addressed last cycle
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            busReq  <= 1'b0;
            RamAddr <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            solved  <= 1'b0;
            filled  <= 1'b0;
            for (int i = 0; i < NUM_ROWS; i++) begin
                rows[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= REQ;
                        busReq <= 1'b1;
                        busy   <= 1'b1;
                        solved <= 1'b0;
                        filled <= 1'b0;
                        for (int i = 0; i < NUM_ROWS; i++) begin
                            rows[i] <= '0;
                        end
                    end
                end
                REQ: begin
                    if (busGrant) begin
                        RamAddr <= '0;
                        state   <= READ;
                    end
                end
                READ: begin
                    if (!busGrant) begin
                        state <= REQ;
                        for (int i = 0; i < NUM_ROWS; i++) begin
                            rows[i] <= '0;
                        end
                    end else begin
                        if (RamAddr != '0) begin
                            rows[RamAddr - 1'b1] <= RamDat[DIGITS_MSB:DIGITS_LSB];
                        end
                        if (RamAddr == ADDR_W'(NUM_ROWS - 1)) begin
                            state <= LAST;
                        end else begin
                            RamAddr <= RamAddr + 1'b1;
                        end
                    end
                end
                LAST: begin
                    if (!busGrant) begin
                        state <= REQ;
                        for (int i = 0; i < NUM_ROWS; i++) begin
                            rows[i] <= '0;
                        end
                    end else begin
                        rows[NUM_ROWS-1] <= RamDat[DIGITS_MSB:DIGITS_LSB];
                        busReq           <= 1'b0;
                        state            <= EVAL;
                    end
                end
                EVAL: begin
                    solved <= boardSolved;
                    filled <= boardFilled;
                    done   <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    busReq <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/sudoku_checker.md
SUDOKU_CHECKER -- requirements
Module: sudoku_checker

Interface
REQ-001 The block SHALL have one clock and a synchronous active-high reset; ports, one per line:
- CLK  in  1  system clock, all logic on rising edge
- RST  in  1  synchronous active-high reset
- start  in  1  one-cycle request to check the current board
- busGrant  in  1  board-RAM access granted to this block
- busReq  out  1  request for board-RAM access
- RamAddr  out  2  board-RAM row address, registered
- RamDat  in  20  board-RAM read word: [19:16] write-protect bits, [15:0] four 4-bit digits, [15:12] leftmost column
- busy  out  1  check in progress
- done  out  1  one-cycle pulse, results valid
- solved  out  1  board is a valid complete solution
- filled  out  1  no blank (0) digit on the board

Function
REQ-002 The FSM SHALL have states IDLE, REQ, READ, LAST, EVAL and DONE.
REQ-003 IDLE: start=1 SHALL move to REQ, clear the row buffer, and set busy=1 in the next cycle.
REQ-004 REQ: busReq=1; busGrant=1 sampled at cycle g SHALL set RamAddr<=0 and move to READ at g+1.
REQ-005 READ SHALL drive RamAddr 0,1,2,3 on consecutive cycles g+1..g+4; RAM read latency is one cycle; row k SHALL be captured from RamDat[15:0] in the cycle after address k is driven.
REQ-006 LAST (g+5) SHALL capture row 3; EVAL (g+6) SHALL register solved/filled and drop busReq; DONE (g+7) SHALL pulse done=1, set busy=0 and return to IDLE.
REQ-007 busReq SHALL be 1 in REQ, READ and LAST only; RamAddr SHALL hold its last value outside READ.
REQ-008 busGrant=0 in READ or LAST SHALL abort the pass, discard captured rows and return to REQ (busReq stays 1); the pass restarts from row 0.
REQ-009 start while busy=1 SHALL be ignored.
REQ-010 filled SHALL be 1 iff all 16 digits are nonzero.
REQ-011 solved SHALL be 1 iff each row and each column contains exactly the digits {1,2,3,4}; any digit 0 or >4 SHALL force solved=0.
REQ-012 Write-protect bits [19:16] SHALL be ignored by the check.
REQ-013 solved and filled SHALL hold from DONE until the next accepted start, which SHALL clear both to 0.

Reset
REQ-014 RST=1 SHALL, in the same clock edge, force state IDLE, busReq=0, RamAddr=0, busy=0, done=0, solved=0, filled=0, and clear the row buffer.
REQ-015 RST asserted mid-pass SHALL abandon the pass with no done pulse.

Configuration
REQ-016 With CHECKER_BOXES_EN defined, solved SHALL additionally require each 2x2 box (rows 0-1/2-3 x columns 0-1/2-3) to contain {1,2,3,4}; without it, boxes are not checked; timing is identical in both builds.

Structure
REQ-017 The shared package SHALL hold the FSM state enum, NUM_ROWS=4, DIGIT_W=4 and the RAM word field positions.
REQ-018 The set check SHALL be one sub-module, sudoku_group_check: four 4-bit digits in, 1-bit "is permutation of 1..4" out, purely combinational, instanced per row, column and (when enabled) box.

Verification
REQ-019 Rows 0x01234,0x03412,0x02143,0x04321, start, grant held -> done at g+7, solved=1, filled=1, RamAddr sequence 0,1,2,3.
REQ-020 Same board, row 1 = 0x03402 -> solved=0, filled=0.
REQ-021 Rows 0x01234,0x02341,0x03412,0x04123 -> solved=1 without CHECKER_BOXES_EN, solved=0 with it; filled=1 in both.
REQ-022 busGrant dropped at g+3 for 2 cycles, then restored -> reads restart at row 0, one done pulse, correct result.
REQ-023 start repeated at g+2, and RST at g+4 in a second run -> repeated start ignored; after RST all outputs 0, no done pulse, next start works normally.
REQ-024 Row 0 = 0x01235 with rows 1-3 otherwise valid -> solved=0, filled=1.
